ccsds123_out_buffer: RTL and testbench

- Downstream stage of ccsds123_top. Captures the packed compressed-word stream (out_tdata/out_tvalid/out_tlast), which has no backpressure.
- Re-emits the stream as a full AXI4-Stream master with tready, buffering through a first-word-fall-through FIFO.
- Reports fill level, an almost-full warning that the system uses to throttle the compressor input, sticky overflow, and a per-image word count.

---
 rtl/ccsds123_out_buffer_pkg.sv | 16 +
 rtl/ccsds123_sdp_ram.sv | 27 ++
 rtl/ccsds123_out_buffer.sv | 107 ++++++++++
 tb/tb_ccsds123_out_buffer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccsds123_out_buffer_pkg.sv
// Shared constants and helpers for the CCSDS-123 output buffer slice.
package ccsds123_out_buffer_pkg;

    localparam int BUS_WIDTH_DEF = 64;

    // Smallest r with 2**r >= value; usable in parameter expressions.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ccsds123_sdp_ram.sv
// Simple dual-port RAM: synchronous write, asynchronous read (maps to distributed RAM).
module ccsds123_sdp_ram
    import ccsds123_out_buffer_pkg::*;
#(
    parameter int WIDTH = 65,
    parameter int DEPTH = 16,
    parameter int AW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/ccsds123_out_buffer.sv
// Buffers the unthrottled compressed-word stream into a FWFT FIFO and re-emits it
// as an AXI4-Stream master, with fill level, almost-full, sticky overflow and image word count.
module ccsds123_out_buffer
    import ccsds123_out_buffer_pkg::*;
#(
    parameter int BUS_WIDTH    = BUS_WIDTH_DEF,
    parameter int DEPTH        = 16,
    parameter int AF_THRESHOLD = 12,
    parameter int CNT_W        = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [BUS_WIDTH-1:0]   in_tdata,
    input  logic                   in_tvalid,
    input  logic                   in_tlast,
    output logic [BUS_WIDTH-1:0]   out_tdata,
    output logic                   out_tvalid,
    input  logic                   out_tready,
    output logic                   out_tlast,
    output logic [clog2(DEPTH):0]  level,
    output logic                   in_almost_full,
    output logic                   overflow,
    output logic                   block_done,
    output logic [CNT_W-1:0]       block_words
);

    localparam int AW = clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [LW-1:0] AF_LVL   = LW'(AF_THRESHOLD);

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNT_W-1:0] word_cnt;
    logic [BUS_WIDTH:0] rd_word;
    logic             push;
    logic             pop;
    logic [LW-1:0]    level_nxt;

    // Handshake: the input side has no ready, so an in_tvalid word is either
    // pushed this cycle or dropped. The output side transfers a word on any
    // edge where out_tvalid & out_tready; while out_tvalid & !out_tready the
    // head entry (data and tlast) is held unchanged.
    assign out_tvalid = (level != '0);
    assign pop        = out_tvalid & out_tready;
    assign push       = in_tvalid & ((level < FULL_LVL) | pop);

    // Gated so the output reads zero whenever nothing is held.
    assign out_tdata = out_tvalid ? rd_word[BUS_WIDTH-1:0] : '0;
    assign out_tlast = out_tvalid & rd_word[BUS_WIDTH];

    always_comb begin
        level_nxt = level;
        if (push & ~pop) begin
            level_nxt = level + LW'(1);
        end else if (pop & ~push) begin
            level_nxt = level - LW'(1);
        end
    end

    ccsds123_sdp_ram #(
        .WIDTH (BUS_WIDTH + 1),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data ({in_tlast, in_tdata}),
        .rd_addr (rd_ptr),
        .rd_data (rd_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            level          <= '0;
            in_almost_full <= 1'b0;
            overflow       <= 1'b0;
            block_done     <= 1'b0;
            block_words    <= '0;
            word_cnt       <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level          <= level_nxt;
            in_almost_full <= (level_nxt >= AF_LVL);
            if (in_tvalid & ~push) begin
                overflow <= 1'b1;
            end
            // A dropped tlast still closes the image.
            block_done <= in_tvalid & in_tlast;
            if (in_tvalid & in_tlast) begin
                block_words <= word_cnt + CNT_W'(push);
                word_cnt    <= '0;
            end else if (push) begin
                word_cnt <= word_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ccsds123_out_buffer.sv
// Directed bench for ccsds123_out_buffer: vector table for pass-through, hand sequences
// for fill, overflow, full pop/push, back-to-back images and mid-image reset.
module tb_ccsds123_out_buffer;

    localparam int W   = 64;
    localparam int D   = 16;
    localparam int AFT = 12;
    localparam int CW  = 32;
    localparam int LW  = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  in_tdata = '0;
    logic          in_tvalid = 1'b0;
    logic          in_tlast = 1'b0;
    logic [W-1:0]  out_tdata;
    logic          out_tvalid;
    logic          out_tready = 1'b0;
    logic          out_tlast;
    logic [LW-1:0] level;
    logic          in_almost_full;
    logic          overflow;
    logic          block_done;
    logic [CW-1:0] block_words;

    int checks = 0;
    int errors = 0;

    logic [W:0]    exp_q[$];
    logic [CW-1:0] bw_q[$];
    logic          mon_en = 1'b0;
    logic          cap_en = 1'b0;

    typedef struct {
        logic          v;
        logic [W-1:0]  d;
        logic          l;
        logic          r;
        logic          e_valid;
        logic [W-1:0]  e_data;
        logic          e_last;
        logic [LW-1:0] e_level;
        logic          e_done;
        logic [CW-1:0] e_words;
    } vec_t;

    vec_t vecs[7];

    ccsds123_out_buffer #(
        .BUS_WIDTH    (W),
        .DEPTH        (D),
        .AF_THRESHOLD (AFT),
        .CNT_W        (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_tdata       (in_tdata),
        .in_tvalid      (in_tvalid),
        .in_tlast       (in_tlast),
        .out_tdata      (out_tdata),
        .out_tvalid     (out_tvalid),
        .out_tready     (out_tready),
        .out_tlast      (out_tlast),
        .level          (level),
        .in_almost_full (in_almost_full),
        .overflow       (overflow),
        .block_done     (block_done),
        .block_words    (block_words)
    );

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge; returns before the next rising edge.
    task automatic step(input logic v, input logic [W-1:0] d, input logic l, input logic r);
        @(negedge clk);
        in_tvalid  = v;
        in_tdata   = d;
        in_tlast   = l;
        out_tready = r;
        #3;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b1;
        in_tvalid  = 1'b0;
        in_tlast   = 1'b0;
        out_tready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #3;
        exp_q.delete();
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_tvalid"}, out_tvalid, 0);
        chk({tag, "_tlast"}, out_tlast, 0);
        chk({tag, "_tdata"}, out_tdata, 0);
        chk({tag, "_level"}, level, 0);
        chk({tag, "_af"}, in_almost_full, 0);
        chk({tag, "_overflow"}, overflow, 0);
        chk({tag, "_done"}, block_done, 0);
        chk({tag, "_words"}, block_words, 0);
    endtask

    task automatic drain(input string name, input int budget, input bit rnd);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step(1'b0, '0, 1'b0, rnd ? 1'($urandom_range(0, 1)) : 1'b1);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: got %0d words left required 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    // Scoreboard: every output transfer must match the oldest expected word.
    always @(negedge clk) begin : monitor
        logic [W:0] e;
        #2;
        if (mon_en && out_tvalid && out_tready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got %0h required none", out_tdata);
            end else begin
                e = exp_q.pop_front();
                chk("out_word", {out_tlast, out_tdata}, e);
            end
        end
        if (cap_en && block_done) begin
            bw_q.push_back(block_words);
        end
    end

    initial begin
        logic [W-1:0] d;
        logic         l;

        //            v  d      l  r  valid data   last level done words
        vecs[0] = '{1'b1, 64'h1, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 5'd0, 1'b0, 32'd0};
        vecs[1] = '{1'b1, 64'h2, 1'b0, 1'b1, 1'b1, 64'h1, 1'b0, 5'd1, 1'b0, 32'd0};
        vecs[2] = '{1'b1, 64'h3, 1'b0, 1'b1, 1'b1, 64'h2, 1'b0, 5'd1, 1'b0, 32'd0};
        vecs[3] = '{1'b1, 64'h4, 1'b0, 1'b1, 1'b1, 64'h3, 1'b0, 5'd1, 1'b0, 32'd0};
        vecs[4] = '{1'b1, 64'h5, 1'b1, 1'b1, 1'b1, 64'h4, 1'b0, 5'd1, 1'b0, 32'd0};
        vecs[5] = '{1'b0, 64'h0, 1'b0, 1'b1, 1'b1, 64'h5, 1'b1, 5'd1, 1'b1, 32'd5};
        vecs[6] = '{1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 5'd0, 1'b0, 32'd5};

        do_reset();
        chk_reset_state("reset");

        // Pass-through table
        for (int i = 0; i < 7; i++) begin
            step(vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].r);
            chk("pt_valid", out_tvalid, vecs[i].e_valid);
            if (vecs[i].e_valid) begin
                chk("pt_data", out_tdata, vecs[i].e_data);
                chk("pt_last", out_tlast, vecs[i].e_last);
            end
            chk("pt_level", level, vecs[i].e_level);
            chk("pt_done", block_done, vecs[i].e_done);
            chk("pt_words", block_words, vecs[i].e_words);
            chk("pt_overflow", overflow, 0);
        end

        // Stall / fill, then overflow attempt, then drain
        do_reset();
        mon_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            d = 64'h101 + 64'(i);
            step(1'b1, d, 1'b0, 1'b0);
            exp_q.push_back({1'b0, d});
            chk("fill_level", level, i);
            chk("fill_af", in_almost_full, (i >= AFT) ? 1 : 0);
            if (i > 0) chk("fill_hold", out_tdata, 64'h101);
        end
        step(1'b1, 64'hAA, 1'b0, 1'b0);
        chk("full_level", level, 16);
        chk("full_af", in_almost_full, 1);
        chk("full_hold", out_tdata, 64'h101);
        chk("full_no_ovf", overflow, 0);
        step(1'b0, '0, 1'b0, 1'b0);
        chk("ovf_set", overflow, 1);
        chk("ovf_level", level, 16);
        drain("ovf_drain", 40, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("ovf_empty_level", level, 0);
        chk("ovf_empty_valid", out_tvalid, 0);
        chk("ovf_sticky", overflow, 1);

        // Full with simultaneous pop and push
        do_reset();
        chk("rst_clears_ovf", overflow, 0);
        for (int i = 0; i < 16; i++) begin
            d = 64'h201 + 64'(i);
            step(1'b1, d, 1'b0, 1'b0);
            exp_q.push_back({1'b0, d});
        end
        step(1'b1, 64'h5A5, 1'b0, 1'b1);
        exp_q.push_back({1'b0, 64'h5A5});
        chk("pp_level_before", level, 16);
        step(1'b0, '0, 1'b0, 1'b0);
        chk("pp_level", level, 16);
        chk("pp_no_ovf", overflow, 0);
        drain("pp_drain", 40, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("pp_empty", level, 0);

        // Back-to-back images with random backpressure
        do_reset();
        bw_q.delete();
        cap_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            d = (i < 3) ? 64'h31 + 64'(i) : 64'h41 + 64'(i - 3);
            l = (i == 2 || i == 4);
            step(1'b1, d, l, 1'($urandom_range(0, 1)));
            exp_q.push_back({l, d});
        end
        drain("b2b_drain", 60, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);
        cap_en = 1'b0;
        chk("b2b_done_count", bw_q.size(), 2);
        if (bw_q.size() >= 2) begin
            chk("b2b_words0", bw_q[0], 3);
            chk("b2b_words1", bw_q[1], 2);
        end
        chk("b2b_no_ovf", overflow, 0);
        mon_en = 1'b0;

        // Reset mid-image
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 64'h301 + 64'(i), 1'b0, 1'b0);
        end
        step(1'b0, '0, 1'b0, 1'b0);
        chk("mid_level", level, 4);
        do_reset();
        chk_reset_state("mid_reset");
        step(1'b1, 64'h401, 1'b0, 1'b1);
        step(1'b1, 64'h402, 1'b1, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("mid_done", block_done, 1);
        chk("mid_words", block_words, 2);
        chk("mid_data", out_tdata, 64'h402);
        chk("mid_last", out_tlast, 1);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("mid_empty", level, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
